// File: rtl/id_fwd_stage_if.sv
// Bundles the IF/WB/forwarding inputs and the ID-stage result buses of id_fwd_stage.
// master drives the stage inputs (upstream/downstream pipeline); slave is the ID stage itself.
interface id_fwd_stage_if #(
  parameter int NUM_FWD = 2
);
  logic [32:0]            if_to_id_bus;
  logic [31:0]            inst_sram_rdata;
  logic [37:0]            wb_to_rf_bus;
  logic [NUM_FWD*39-1:0]  fwd_bus;
  logic [158:0]           id_to_ex_bus;
  logic [32:0]            br_bus;
  logic                   stallreq;

  modport master (
    output if_to_id_bus, inst_sram_rdata, wb_to_rf_bus, fwd_bus,
    input  id_to_ex_bus, br_bus, stallreq
  );

  modport slave (
    input  if_to_id_bus, inst_sram_rdata, wb_to_rf_bus, fwd_bus,
    output id_to_ex_bus, br_bus, stallreq
  );
endinterface

// File: rtl/id_fwd_stage.sv
// ID stage: decode, operand forwarding/WB bypass, branch resolve; ID_BRANCH_EXT_EN adds bne/j/jal.
// Latency: all outputs combinational from the ID register and instruction-hold state.
// Backpressure: stall[1] holds/bubbles ID, stall[2] freezes the fetched word; stallreq flags load-use.
module id_fwd_stage #(
  parameter int NUM_FWD = 2,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  id_fwd_stage_if.slave      bus
);

  typedef enum logic {RUN, HOLD} hold_state_e;

  typedef struct packed {
    logic        is_load;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } fwd_src_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } wb_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
  } id_ex_t;

  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef ID_BRANCH_EXT_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [2:0] SRC1_PC  = 3'b010;
  localparam logic [3:0] SRC2_8   = 4'b0010;
`endif

  // alu_op one-hot: [11]=ADD, [5]=OR, [0]=LUI; src1 [0]=rs [1]=pc; src2 [0]=sext imm [1]=8 [2]=zext imm
  localparam logic [11:0] ALU_ADD   = 12'h800;
  localparam logic [11:0] ALU_OR    = 12'h020;
  localparam logic [11:0] ALU_LUI   = 12'h001;
  localparam logic [2:0]  SRC1_RS   = 3'b001;
  localparam logic [3:0]  SRC2_SIMM = 4'b0001;
  localparam logic [3:0]  SRC2_ZIMM = 4'b0100;

  logic        id_ce;
  logic [31:0] id_pc;
  hold_state_e state;
  logic [31:0] inst_hold;
  logic [31:0] rf [32];

  wb_t         wb;
  fwd_src_t    src [NUM_FWD];
  logic [31:0] inst;
  logic [4:0]  rs, rt;
  logic [15:0] imm;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic        rd_rs, rd_rt, is_beq, is_bne, is_j;
  logic [31:0] rs_val, rt_val;
  logic        load_use;
  logic [31:0] pc_plus4, br_target, jump_target;
  logic        br_take;
  id_ex_t      ex;
  logic        unused_stall;

  assign unused_stall = ^{stall[STALL_W-1:3], stall[0]};

  assign wb = bus.wb_to_rf_bus;
  always_comb begin
    for (int i = 0; i < NUM_FWD; i++) src[i] = bus.fwd_bus[i*39 +: 39];
  end

  // flush outranks every stall combination
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      {id_ce, id_pc} <= '0;
    end else if (!stall[1]) begin
      {id_ce, id_pc} <= bus.if_to_id_bus;
    end else if (!stall[2]) begin
      {id_ce, id_pc} <= '0;
    end
  end

  // The SRAM word only lives one cycle, so park it while ID is frozen.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= RUN;
      inst_hold <= '0;
    end else begin
      case (state)
        RUN: begin
          if (stall[2] && id_ce) begin
            state     <= HOLD;
            inst_hold <= bus.inst_sram_rdata;
          end
        end
        HOLD: begin
          if (!stall[2]) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wb.we && wb.waddr != 5'd0) rf[wb.waddr] <= wb.wdata;
  end

  assign inst = !id_ce ? 32'd0 : (state == HOLD) ? inst_hold : bus.inst_sram_rdata;
  assign rs   = inst[25:21];
  assign rt   = inst[20:16];
  assign imm  = inst[15:0];

  always_comb begin
    alu_op   = '0;
    sel_src1 = '0;
    sel_src2 = '0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rd_rs    = 1'b0;
    rd_rt    = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    case (inst[31:26])
      OP_ORI: begin
        alu_op = ALU_OR;  sel_src1 = SRC1_RS; sel_src2 = SRC2_ZIMM;
        rf_we  = 1'b1;    rf_waddr = rt;      rd_rs    = 1'b1;
      end
      OP_LUI: begin
        alu_op = ALU_LUI; sel_src2 = SRC2_ZIMM;
        rf_we  = 1'b1;    rf_waddr = rt;
      end
      OP_ADDIU: begin
        alu_op = ALU_ADD; sel_src1 = SRC1_RS; sel_src2 = SRC2_SIMM;
        rf_we  = 1'b1;    rf_waddr = rt;      rd_rs    = 1'b1;
      end
      OP_BEQ: begin
        rd_rs = 1'b1; rd_rt = 1'b1; is_beq = 1'b1;
      end
`ifdef ID_BRANCH_EXT_EN
      OP_BNE: begin
        rd_rs = 1'b1; rd_rt = 1'b1; is_bne = 1'b1;
      end
      OP_J: begin
        is_j = 1'b1;
      end
      OP_JAL: begin
        is_j   = 1'b1;    alu_op   = ALU_ADD; sel_src1 = SRC1_PC; sel_src2 = SRC2_8;
        rf_we  = 1'b1;    rf_waddr = 5'd31;
      end
`endif
      default: ;
    endcase
  end

  // Nearest non-load producer wins; loads are never forwarded from here.
  always_comb begin
    rs_val = (rs == 5'd0) ? 32'd0 : (wb.we && wb.waddr == rs) ? wb.wdata : rf[rs];
    rt_val = (rt == 5'd0) ? 32'd0 : (wb.we && wb.waddr == rt) ? wb.wdata : rf[rt];
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (src[i].we && !src[i].is_load && src[i].waddr == rs && rs != 5'd0) rs_val = src[i].wdata;
      if (src[i].we && !src[i].is_load && src[i].waddr == rt && rt != 5'd0) rt_val = src[i].wdata;
    end
  end

  always_comb begin
    load_use = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (src[i].is_load && src[i].we && src[i].waddr != 5'd0 &&
          ((rd_rs && src[i].waddr == rs) || (rd_rt && src[i].waddr == rt)))
        load_use = 1'b1;
    end
  end

  assign pc_plus4    = id_pc + 32'd4;
  assign br_target   = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  assign jump_target = {pc_plus4[31:28], inst[25:0], 2'b00};
  assign br_take     = !load_use && ((is_beq && rs_val == rt_val) ||
                                     (is_bne && rs_val != rt_val) || is_j);

  always_comb begin
    ex              = '0;
    ex.pc           = id_pc;
    ex.inst         = inst;
    ex.alu_op       = alu_op;
    ex.sel_alu_src1 = sel_src1;
    ex.sel_alu_src2 = sel_src2;
    ex.rf_we        = rf_we;
    ex.rf_waddr     = rf_waddr;
    ex.rs_val       = rs_val;
    ex.rt_val       = rt_val;
  end

  assign bus.id_to_ex_bus = ex;
  assign bus.br_bus       = br_take ? {1'b1, is_j ? jump_target : br_target} : 33'd0;
  assign bus.stallreq     = load_use;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Bench for id_fwd_stage: directed vector table, hold/flush/reset sequences, random vs reference model.
module tb_id_fwd_stage;
  localparam int NF = 2;
`ifdef ID_BRANCH_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  localparam logic [5:0] OP_ORI = 6'b001101, OP_LUI = 6'b001111, OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [11:0] ALU_ADD = 12'h800, ALU_OR = 12'h020, ALU_LUI = 12'h001;
  localparam logic [2:0] S1_RS = 3'b001, S1_PC = 3'b010;
  localparam logic [3:0] S2_SIMM = 4'b0001, S2_8 = 4'b0010, S2_ZIMM = 4'b0100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [5:0] stall = '0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] rf_m [32];

  id_fwd_stage_if #(.NUM_FWD(NF)) bus ();

  id_fwd_stage #(.NUM_FWD(NF), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [32:0] ifb;
    logic [31:0] inst;
    logic [37:0] wb;
    logic [77:0] fwd;
    logic        e_st;
    logic [32:0] e_br;
    logic [31:0] e_rs;
    logic [30:0] e_ctrl;
  } vec_t;

  vec_t vt[$];

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                                        input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic logic [38:0] fsrc(input logic ld, input logic we, input logic [4:0] wa,
                                       input logic [31:0] d);
    return {ld, we, wa, d};
  endfunction

  function automatic logic [37:0] wbw(input logic we, input logic [4:0] wa, input logic [31:0] d);
    return {we, wa, d};
  endfunction

  function automatic logic [30:0] ctrl(input logic [11:0] a, input logic [2:0] s1, input logic [3:0] s2,
                                       input logic we, input logic [4:0] wa);
    return {a, s1, s2, 1'b0, 4'b0000, we, wa, 1'b0};
  endfunction

  function automatic vec_t mkv(input string nm, input logic [32:0] ifb, input logic [31:0] inst,
                               input logic [37:0] wb, input logic [77:0] fwd, input logic e_st,
                               input logic [32:0] e_br, input logic [31:0] e_rs, input logic [30:0] e_ctrl);
    vec_t v;
    v.nm = nm; v.ifb = ifb; v.inst = inst; v.wb = wb; v.fwd = fwd;
    v.e_st = e_st; v.e_br = e_br; v.e_rs = e_rs; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [158:0] act, input logic [158:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Commits this cycle's WB write into the model, then advances one clock.
  task automatic step();
    if (bus.wb_to_rf_bus[37] && bus.wb_to_rf_bus[36:32] != 5'd0)
      rf_m[bus.wb_to_rf_bus[36:32]] = bus.wb_to_rf_bus[31:0];
    @(posedge clk);
    #1;
  endtask

  task automatic load_id(input logic [32:0] ifb);
    bus.if_to_id_bus = ifb;
    stall = '0;
    flush = 1'b0;
    step();
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic [77:0] fwd, input logic [37:0] wb);
    logic [38:0] s;
    if (r == 5'd0) return 32'd0;
    for (int i = 0; i < NF; i++) begin
      s = fwd[i*39 +: 39];
      if (s[37] && !s[38] && s[36:32] == r) return s[31:0];
    end
    if (wb[37] && wb[36:32] == r) return wb[31:0];
    return rf_m[r];
  endfunction

  function automatic void model(input logic [32:0] ifb, input logic [31:0] sram, input logic [77:0] fwd,
                                input logic [37:0] wb, output logic [158:0] e_ex,
                                output logic [32:0] e_br, output logic e_st);
    logic [31:0] pc, ins, simm, rsv, rtv, tgt, pc4;
    logic [4:0]  rs, rt, wa;
    logic [11:0] alu;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        we, use_rs, use_rt, take;
    logic [38:0] s;
    pc   = ifb[31:0];
    ins  = ifb[32] ? sram : 32'd0;
    rs   = ins[25:21];
    rt   = ins[20:16];
    simm = {{16{ins[15]}}, ins[15:0]};
    pc4  = pc + 32'd4;
    rsv  = opnd(rs, fwd, wb);
    rtv  = opnd(rt, fwd, wb);
    alu = '0; s1 = '0; s2 = '0; we = 1'b0; wa = '0;
    use_rs = 1'b0; use_rt = 1'b0; take = 1'b0; tgt = '0;
    case (ins[31:26])
      OP_ORI:   begin alu = ALU_OR;  s1 = S1_RS; s2 = S2_ZIMM; we = 1'b1; wa = rt; use_rs = 1'b1; end
      OP_LUI:   begin alu = ALU_LUI; s2 = S2_ZIMM; we = 1'b1; wa = rt; end
      OP_ADDIU: begin alu = ALU_ADD; s1 = S1_RS; s2 = S2_SIMM; we = 1'b1; wa = rt; use_rs = 1'b1; end
      OP_BEQ:   begin use_rs = 1'b1; use_rt = 1'b1; take = (rsv == rtv); tgt = pc4 + (simm << 2); end
      OP_BNE: if (EXT) begin use_rs = 1'b1; use_rt = 1'b1; take = (rsv != rtv); tgt = pc4 + (simm << 2); end
      OP_J:   if (EXT) begin take = 1'b1; tgt = {pc4[31:28], ins[25:0], 2'b00}; end
      OP_JAL: if (EXT) begin
        take = 1'b1; tgt = {pc4[31:28], ins[25:0], 2'b00};
        alu = ALU_ADD; s1 = S1_PC; s2 = S2_8; we = 1'b1; wa = 5'd31;
      end
      default: ;
    endcase
    e_st = 1'b0;
    for (int i = 0; i < NF; i++) begin
      s = fwd[i*39 +: 39];
      if (s[38] && s[37] && s[36:32] != 5'd0 &&
          ((use_rs && s[36:32] == rs) || (use_rt && s[36:32] == rt)))
        e_st = 1'b1;
    end
    e_br = (take && !e_st) ? {1'b1, tgt} : 33'd0;
    e_ex = {pc, ins, alu, s1, s2, 1'b0, 4'b0000, we, wa, 1'b0, rsv, rtv};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a_w, b_w;
    logic [158:0] e_ex;
    logic [32:0]  e_br;
    logic         e_st;
    logic [38:0]  s0, s1;
    logic [5:0]   ops [8];

    ops[0] = OP_ORI; ops[1] = OP_LUI; ops[2] = OP_ADDIU; ops[3] = OP_BEQ;
    ops[4] = OP_BNE; ops[5] = OP_J;   ops[6] = OP_JAL;   ops[7] = 6'h23;

    vt.push_back(mkv("addiu_fwd0", {1'b1, 32'h100}, itype(OP_ADDIU, 1, 2, 16'd5), '0,
                     {39'd0, fsrc(0, 1, 1, 32'h10)}, 0, '0, 32'h10, ctrl(ALU_ADD, S1_RS, S2_SIMM, 1, 2)));
    vt.push_back(mkv("ori_loaduse", {1'b1, 32'h100}, itype(OP_ORI, 3, 4, 16'd1), '0,
                     {39'd0, fsrc(1, 1, 3, 32'h55)}, 1, '0, 32'h103, ctrl(ALU_OR, S1_RS, S2_ZIMM, 1, 4)));
    vt.push_back(mkv("ori_noload", {1'b1, 32'h100}, itype(OP_ORI, 3, 4, 16'd1), '0,
                     {39'd0, fsrc(0, 1, 3, 32'h55)}, 0, '0, 32'h55, ctrl(ALU_OR, S1_RS, S2_ZIMM, 1, 4)));
    vt.push_back(mkv("ori_wb_byp", {1'b1, 32'h100}, itype(OP_ORI, 5, 6, 16'd0), wbw(1, 5, 32'hAB),
                     '0, 0, '0, 32'hAB, ctrl(ALU_OR, S1_RS, S2_ZIMM, 1, 6)));
    vt.push_back(mkv("ori_wb_r0", {1'b1, 32'h100}, itype(OP_ORI, 0, 6, 16'd0), wbw(1, 0, 32'hAB),
                     '0, 0, '0, 32'h0, ctrl(ALU_OR, S1_RS, S2_ZIMM, 1, 6)));
    vt.push_back(mkv("beq_taken", {1'b1, 32'h1000}, itype(OP_BEQ, 7, 7, 16'hFFFF), '0,
                     '0, 0, {1'b1, 32'h1000}, 32'h107, '0));
    vt.push_back(mkv("beq_not", {1'b1, 32'h1000}, itype(OP_BEQ, 7, 8, 16'hFFFF), '0,
                     '0, 0, '0, 32'h107, '0));
    vt.push_back(mkv("beq_loadstall", {1'b1, 32'h1000}, itype(OP_BEQ, 7, 7, 16'hFFFF), '0,
                     {fsrc(1, 1, 7, 32'h0), 39'd0}, 1, '0, 32'h107, '0));
    vt.push_back(mkv("lui_noread", {1'b1, 32'h100}, itype(OP_LUI, 0, 9, 16'h1234), '0,
                     {39'd0, fsrc(1, 1, 9, 32'h0)}, 0, '0, 32'h0, ctrl(ALU_LUI, 3'b000, S2_ZIMM, 1, 9)));
    vt.push_back(mkv("fwd_prio", {1'b1, 32'h100}, itype(OP_ADDIU, 1, 2, 16'd5), wbw(1, 1, 32'h33),
                     {fsrc(0, 1, 1, 32'h22), fsrc(0, 1, 1, 32'h11)}, 0, '0, 32'h11,
                     ctrl(ALU_ADD, S1_RS, S2_SIMM, 1, 2)));
    vt.push_back(mkv("fwd1_over_wb", {1'b1, 32'h100}, itype(OP_ADDIU, 1, 2, 16'd5), wbw(1, 1, 32'h66),
                     {fsrc(0, 1, 1, 32'h22), fsrc(0, 1, 2, 32'h44)}, 0, '0, 32'h22,
                     ctrl(ALU_ADD, S1_RS, S2_SIMM, 1, 2)));
    vt.push_back(mkv("fwd_load_skip", {1'b1, 32'h100}, itype(OP_ADDIU, 1, 2, 16'd5), '0,
                     {fsrc(0, 1, 1, 32'h22), fsrc(1, 1, 1, 32'h77)}, 1, '0, 32'h22,
                     ctrl(ALU_ADD, S1_RS, S2_SIMM, 1, 2)));
    vt.push_back(mkv("ce0_kill", {1'b0, 32'h200}, itype(OP_ADDIU, 1, 2, 16'd5), '0,
                     '0, 0, '0, 32'h0, '0));
    vt.push_back(mkv("jal", {1'b1, 32'h8000_0000}, {OP_JAL, 26'h10}, '0, '0, 0,
                     EXT ? {1'b1, 32'h8000_0040} : 33'd0, 32'h0,
                     EXT ? ctrl(ALU_ADD, S1_PC, S2_8, 1, 31) : 31'd0));
    vt.push_back(mkv("bne", {1'b1, 32'h2000}, itype(OP_BNE, 7, 8, 16'd1), '0, '0, 0,
                     EXT ? {1'b1, 32'h2008} : 33'd0, 32'h107, '0));
    vt.push_back(mkv("unknown_op", {1'b1, 32'h100}, itype(6'h23, 3, 2, 16'd4), '0,
                     '0, 0, '0, 32'h103, '0));

    // Reset: ID empty, all outputs zero even with live inputs
    bus.if_to_id_bus    = {1'b1, 32'h1234_5678};
    bus.inst_sram_rdata = 32'h2422_0005;
    bus.wb_to_rf_bus    = '0;
    bus.fwd_bus         = {fsrc(1, 1, 2, 32'h5), fsrc(1, 1, 1, 32'h9)};
    step();
    step();
    #2;
    chk("rst_id_to_ex", bus.id_to_ex_bus, '0);
    chk("rst_br", bus.br_bus, '0);
    chk("rst_stallreq", bus.stallreq, '0);
    rst = 1'b0;
    bus.if_to_id_bus = '0;
    bus.fwd_bus      = '0;

    for (int r = 1; r < 32; r++) begin
      bus.wb_to_rf_bus = wbw(1'b1, r[4:0], 32'h100 + r);
      step();
    end
    bus.wb_to_rf_bus = '0;

    foreach (vt[i]) begin
      load_id(vt[i].ifb);
      bus.inst_sram_rdata = vt[i].inst;
      bus.fwd_bus         = vt[i].fwd;
      bus.wb_to_rf_bus    = vt[i].wb;
      #2;
      chk({vt[i].nm, "_stallreq"}, bus.stallreq, vt[i].e_st);
      chk({vt[i].nm, "_br"}, bus.br_bus, vt[i].e_br);
      chk({vt[i].nm, "_rs_val"}, bus.id_to_ex_bus[63:32], vt[i].e_rs);
      chk({vt[i].nm, "_ctrl"}, bus.id_to_ex_bus[94:64], vt[i].e_ctrl);
    end
    bus.fwd_bus = '0;
    bus.wb_to_rf_bus = '0;

    // Three stall cycles with the SRAM word changing underneath
    a_w = itype(OP_ADDIU, 1, 2, 16'd5);
    b_w = itype(OP_ORI, 3, 4, 16'd1);
    load_id({1'b1, 32'h40});
    bus.inst_sram_rdata = a_w;
    stall = 6'b000111;
    #2;
    chk("hold_c0_inst", bus.id_to_ex_bus[126:95], a_w);
    step();
    for (int k = 1; k < 3; k++) begin
      bus.inst_sram_rdata = $urandom;
      #2;
      chk("hold_inst", bus.id_to_ex_bus[126:95], a_w);
      chk("hold_pc", bus.id_to_ex_bus[158:127], 32'h40);
      step();
    end
    stall = '0;
    bus.if_to_id_bus = {1'b1, 32'h44};
    bus.inst_sram_rdata = $urandom;
    #2;
    chk("hold_issue_inst", bus.id_to_ex_bus[126:95], a_w);
    step();
    bus.inst_sram_rdata = b_w;
    #2;
    chk("hold_next_inst", bus.id_to_ex_bus[126:95], b_w);
    chk("hold_next_pc", bus.id_to_ex_bus[158:127], 32'h44);

    // stall[1] alone inserts a bubble
    load_id({1'b1, 32'h50});
    bus.inst_sram_rdata = a_w;
    stall = 6'b000010;
    step();
    #2;
    chk("bubble_bus", bus.id_to_ex_bus, '0);

    // flush beats a full stall
    load_id({1'b1, 32'h60});
    bus.inst_sram_rdata = a_w;
    stall = 6'b000111;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #2;
    chk("flush_stall_bus", bus.id_to_ex_bus, '0);

    // Reset while holding must discard the parked word
    load_id({1'b1, 32'h70});
    bus.inst_sram_rdata = a_w;
    stall = 6'b000111;
    step();
    bus.inst_sram_rdata = $urandom;
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("rst_hold_bus", bus.id_to_ex_bus, '0);
    chk("rst_hold_br", bus.br_bus, '0);
    stall = 6'b000100;
    bus.if_to_id_bus = {1'b1, 32'h74};
    step();
    bus.inst_sram_rdata = b_w;
    #2;
    chk("rst_drop_hold_inst", bus.id_to_ex_bus[126:95], b_w);
    stall = '0;

    for (int it = 0; it < 300; it++) begin
      load_id({($urandom_range(0, 7) != 0), $urandom & 32'hFFFF_FFFC});
      bus.inst_sram_rdata = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                             5'($urandom_range(0, 7)), 16'($urandom)};
      if (bus.inst_sram_rdata[31:27] == 5'b00001) bus.inst_sram_rdata[25:0] = 26'($urandom);
      s0 = fsrc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
      s1 = fsrc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom);
      bus.fwd_bus = {s1, s0};
      bus.wb_to_rf_bus = wbw($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      #2;
      model(bus.if_to_id_bus, bus.inst_sram_rdata, bus.fwd_bus, bus.wb_to_rf_bus, e_ex, e_br, e_st);
      chk("rnd_id_to_ex", bus.id_to_ex_bus, e_ex);
      chk("rnd_br", bus.br_bus, e_br);
      chk("rnd_stallreq", bus.stallreq, e_st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
